// File: rtl/fir_pkg.sv
// Shared types and helpers for the multi-channel decimating FIR core:
// accumulator sizing, coefficient unpacking and the sequencer state encoding.
package fir_pkg;

    localparam int MAX_DATA_WIDTH = 64;
    localparam int MAX_COEFF_BITS = 16384;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        MAC   = 2'd1,
        WRITE = 2'd2
    } fir_state_e;

    // Headroom of $clog2(taps) bits means a full sum of products cannot overflow.
    function automatic int acc_width(input int data_width, input int taps);
        return 2 * data_width + $clog2(taps);
    endfunction

    // coeff[0] sits in the most-significant slot of the packed vector.
    function automatic logic [MAX_DATA_WIDTH-1:0] get_coeff(
        input logic [MAX_COEFF_BITS-1:0] coeffs,
        input int                        taps,
        input int                        data_width,
        input int                        k
    );
        return MAX_DATA_WIDTH'(coeffs >> ((taps - 1 - k) * data_width));
    endfunction

endpackage

// File: rtl/fir_mac.sv
// Single shared multiply-accumulate lane: one product per enabled cycle,
// result presented as the arithmetic-shifted, truncated accumulator.
module fir_mac
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TAPS       = 32,
    parameter int FRAC_BITS  = 10
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         enable,
    input  logic signed [DATA_WIDTH-1:0] sample,
    input  logic signed [DATA_WIDTH-1:0] coeff,
    output logic signed [DATA_WIDTH-1:0] y
);

    localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, TAPS);
    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    localparam int EXT_WIDTH  = ACC_WIDTH - PROD_WIDTH;

    logic signed [PROD_WIDTH-1:0] sample_ext_s;
    logic signed [PROD_WIDTH-1:0] coeff_ext_s;
    logic signed [PROD_WIDTH-1:0] product_s;
    logic signed [ACC_WIDTH-1:0]  product_acc_s;
    logic signed [ACC_WIDTH-1:0]  acc_r;

    assign sample_ext_s  = $signed({{DATA_WIDTH{sample[DATA_WIDTH-1]}}, sample});
    assign coeff_ext_s   = $signed({{DATA_WIDTH{coeff[DATA_WIDTH-1]}}, coeff});
    assign product_s     = sample_ext_s * coeff_ext_s;
    assign product_acc_s = $signed({{EXT_WIDTH{product_s[PROD_WIDTH-1]}}, product_s});

    // Accumulator: clear has priority over accumulate so a new pass starts from zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_r <= {ACC_WIDTH{1'b0}};
        end else if (clear) begin
            acc_r <= {ACC_WIDTH{1'b0}};
        end else if (enable) begin
            acc_r <= acc_r + product_acc_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    // Floor rounding falls out of the arithmetic shift; upper bits are simply dropped.
    assign y = DATA_WIDTH'(acc_r >>> FRAC_BITS);

endmodule

// File: rtl/fir_decim_mc.sv
// Multi-channel decimating FIR: buffers interleaved input frames into per-channel
// histories, then runs one time-shared MAC pass per channel and pushes each result.
module fir_decim_mc
    import fir_pkg::*;
#(
    parameter int                          DATA_WIDTH = 32,
    parameter int                          TAPS       = 32,
    parameter int                          DECIMATION = 8,
    parameter int                          CHANNELS   = 2,
    parameter int                          FRAC_BITS  = 10,
    parameter logic [TAPS*DATA_WIDTH-1:0]  COEFF      = {(TAPS*DATA_WIDTH){1'b0}},
    localparam int                         CHAN_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] x_in,
    input  logic                         x_empty,
    output logic                         x_rd_en,
    output logic signed [DATA_WIDTH-1:0] y_out,
    output logic [CHAN_WIDTH-1:0]        y_chan,
    input  logic                         y_out_full,
    output logic                         y_wr_en
);

    localparam int FRAME_WIDTH = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
    localparam int TAP_WIDTH   = $clog2(TAPS);

    localparam logic [CHAN_WIDTH-1:0]  LAST_CHAN  = CHAN_WIDTH'(CHANNELS - 1);
    localparam logic [FRAME_WIDTH-1:0] LAST_FRAME = FRAME_WIDTH'(DECIMATION - 1);
    localparam logic [TAP_WIDTH-1:0]   LAST_TAP   = TAP_WIDTH'(TAPS - 1);

    fir_state_e                    state_r;
    fir_state_e                    state_s;
    logic                          pop_s;
    logic                          push_s;
    logic                          mac_clear_s;
    logic                          mac_en_s;
    logic [CHAN_WIDTH-1:0]         chan_cnt_r;
    logic [FRAME_WIDTH-1:0]        frame_cnt_r;
    logic [CHAN_WIDTH-1:0]         ch_r;
    logic [TAP_WIDTH-1:0]          k_r;
    logic signed [DATA_WIDTH-1:0]  x_hist_r [CHANNELS][TAPS];
    logic signed [DATA_WIDTH-1:0]  coeff_tab [TAPS];
    logic signed [DATA_WIDTH-1:0]  mac_sample_s;
    logic signed [DATA_WIDTH-1:0]  mac_coeff_s;
    logic signed [DATA_WIDTH-1:0]  mac_y_s;

    for (genvar t = 0; t < TAPS; t++) begin : g_coeff
        assign coeff_tab[t] = DATA_WIDTH'(get_coeff(MAX_COEFF_BITS'(COEFF), TAPS, DATA_WIDTH, t));
    end

    // Sequencer next-state and per-cycle strobes.
    always_comb begin
        state_s     = state_r;
        pop_s       = 1'b0;
        push_s      = 1'b0;
        mac_clear_s = 1'b0;
        mac_en_s    = 1'b0;
        case (state_r)
            LOAD: begin
                if (!x_empty) begin
                    pop_s = 1'b1;
                    if ((chan_cnt_r == LAST_CHAN) && (frame_cnt_r == LAST_FRAME)) begin
                        state_s     = MAC;
                        mac_clear_s = 1'b1;
                    end else begin
                        state_s = LOAD;
                    end
                end else begin
                    state_s = LOAD;
                end
            end
            MAC: begin
                mac_en_s = 1'b1;
                if (k_r == LAST_TAP) begin
                    state_s = WRITE;
                end else begin
                    state_s = MAC;
                end
            end
            WRITE: begin
                if (!y_out_full) begin
                    push_s = 1'b1;
                    if (ch_r == LAST_CHAN) begin
                        state_s = LOAD;
                    end else begin
                        state_s     = MAC;
                        mac_clear_s = 1'b1;
                    end
                end else begin
                    state_s = WRITE;
                end
            end
            default: begin
                state_s = LOAD;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_s;
        end
    end

    // Input position within the current frame and decimation period.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chan_cnt_r  <= {CHAN_WIDTH{1'b0}};
            frame_cnt_r <= {FRAME_WIDTH{1'b0}};
        end else if (pop_s) begin
            if (chan_cnt_r == LAST_CHAN) begin
                chan_cnt_r  <= {CHAN_WIDTH{1'b0}};
                frame_cnt_r <= (frame_cnt_r == LAST_FRAME) ? {FRAME_WIDTH{1'b0}}
                                                           : frame_cnt_r + FRAME_WIDTH'(1);
            end else begin
                chan_cnt_r  <= chan_cnt_r + CHAN_WIDTH'(1);
                frame_cnt_r <= frame_cnt_r;
            end
        end else begin
            chan_cnt_r  <= chan_cnt_r;
            frame_cnt_r <= frame_cnt_r;
        end
    end

    // Per-channel delay lines; only the channel being popped shifts.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int t = 0; t < TAPS; t++) begin
                    x_hist_r[c][t] <= {DATA_WIDTH{1'b0}};
                end
            end
        end else if (pop_s) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (chan_cnt_r == CHAN_WIDTH'(c)) begin
                    x_hist_r[c][0] <= x_in;
                    for (int t = 1; t < TAPS; t++) begin
                        x_hist_r[c][t] <= x_hist_r[c][t-1];
                    end
                end
            end
        end
    end

    // Tap index walks the history during MAC; ch_r selects the channel being filtered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            k_r  <= {TAP_WIDTH{1'b0}};
            ch_r <= {CHAN_WIDTH{1'b0}};
        end else begin
            if (state_r == MAC) begin
                k_r <= (k_r == LAST_TAP) ? {TAP_WIDTH{1'b0}} : k_r + TAP_WIDTH'(1);
            end else begin
                k_r <= {TAP_WIDTH{1'b0}};
            end
            if (pop_s && (state_s == MAC)) begin
                ch_r <= {CHAN_WIDTH{1'b0}};
            end else if (push_s) begin
                ch_r <= (ch_r == LAST_CHAN) ? {CHAN_WIDTH{1'b0}} : ch_r + CHAN_WIDTH'(1);
            end else begin
                ch_r <= ch_r;
            end
        end
    end

    assign mac_sample_s = x_hist_r[ch_r][k_r];
    assign mac_coeff_s  = coeff_tab[k_r];

    fir_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .TAPS       (TAPS),
        .FRAC_BITS  (FRAC_BITS)
    ) u_mac (
        .clock  (clock),
        .reset  (reset),
        .clear  (mac_clear_s),
        .enable (mac_en_s),
        .sample (mac_sample_s),
        .coeff  (mac_coeff_s),
        .y      (mac_y_s)
    );

    // Handshakes are gated by reset so they drop without waiting for a clock edge.
    assign x_rd_en = pop_s & ~reset;
    assign y_wr_en = push_s & ~reset;
    assign y_out   = mac_y_s;
    assign y_chan  = ch_r;

endmodule

// File: tb/tb_fir_decim_mc.sv
// Directed bench for fir_decim_mc: FIFO models around the core, hand-computed
// expected outputs for impulse, step, negative, stall, starvation and reset cases.
module tb_fir_decim_mc;

    localparam int DW   = 32;
    localparam int TAPS = 32;
    localparam int DEC  = 8;
    localparam int CH   = 2;
    localparam int FRAC = 10;

    function automatic logic [TAPS*DW-1:0] make_coeff();
        logic [TAPS*DW-1:0] v;
        v = {(TAPS*DW){1'b0}};
        for (int k = 0; k < TAPS; k++) begin
            v[(TAPS-1-k)*DW +: DW] = DW'(k + 1);
        end
        return v;
    endfunction

    localparam logic [TAPS*DW-1:0] COEFF = make_coeff();

    logic                 clock = 1'b0;
    logic                 reset;
    logic signed [DW-1:0] x_in;
    logic                 x_empty;
    logic                 x_rd_en;
    logic signed [DW-1:0] y_out;
    logic [0:0]           y_chan;
    logic                 y_out_full;
    logic                 y_wr_en;

    logic signed [DW-1:0] q[$];
    logic signed [DW-1:0] out_y[$];
    logic [0:0]           out_c[$];
    int                   exp_y[$];
    int                   exp_c[$];
    int                   pop_cnt;
    int                   rd_viol;
    int                   wr_viol;
    int                   errors;
    int                   checks;
    int                   stall_bad;
    bit                   starve;
    logic                 hold;
    logic signed [DW-1:0] snap;

    fir_decim_mc #(
        .DATA_WIDTH (DW),
        .TAPS       (TAPS),
        .DECIMATION (DEC),
        .CHANNELS   (CH),
        .FRAC_BITS  (FRAC),
        .COEFF      (COEFF)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .x_in       (x_in),
        .x_empty    (x_empty),
        .x_rd_en    (x_rd_en),
        .y_out      (y_out),
        .y_chan     (y_chan),
        .y_out_full (y_out_full),
        .y_wr_en    (y_wr_en)
    );

    always #5 clock = ~clock;

    // Show-ahead upstream FIFO: inputs change only on the falling edge.
    always @(negedge clock) begin
        hold    = starve && ($urandom_range(0, 1) == 1);
        x_empty = (q.size() == 0) || hold;
        x_in    = (q.size() != 0) ? q[0] : 32'sd0;
    end

    // Pop/push bookkeeping and handshake protocol monitors.
    always @(posedge clock) begin
        if (x_rd_en && x_empty) rd_viol++;
        if (y_wr_en && y_out_full) wr_viol++;
        if (x_rd_en && (q.size() != 0)) begin
            void'(q.pop_front());
            pop_cnt++;
        end
        if (y_wr_en) begin
            out_y.push_back(y_out);
            out_c.push_back(y_chan);
        end
    end

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
        q.push_back(a);
        q.push_back(b);
    endtask

    task automatic expect_pair(input int y0, input int y1);
        exp_y.push_back(y0);
        exp_c.push_back(0);
        exp_y.push_back(y1);
        exp_c.push_back(1);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        y_out_full = 1'b0;
        starve     = 1'b0;
        repeat (2) @(negedge clock);
        q.delete();
        out_y.delete();
        out_c.delete();
        exp_y.delete();
        exp_c.delete();
        pop_cnt = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic feed_impulse();
        for (int f = 0; f < 40; f++) begin
            push_frame((f == 0) ? 32'sd1024 : 32'sd0, 32'sd0);
        end
        expect_pair(8, 0);
        expect_pair(16, 0);
        expect_pair(24, 0);
        expect_pair(32, 0);
        expect_pair(0, 0);
    endtask

    task automatic feed_dc();
        for (int f = 0; f < 40; f++) begin
            push_frame(32'sd0, 32'sd1024);
        end
        expect_pair(0, 36);
        expect_pair(0, 136);
        expect_pair(0, 300);
        expect_pair(0, 528);
        expect_pair(0, 528);
    endtask

    task automatic wait_pops(input string tag, input int n, input int budget);
        int waited;
        waited = 0;
        while ((pop_cnt < n) && (waited < budget)) begin
            @(negedge clock);
            waited++;
        end
        check({tag, " pops"}, pop_cnt, n);
    endtask

    task automatic compare_outs(input string tag, input int budget);
        int n;
        int waited;
        n      = exp_y.size();
        waited = 0;
        while ((out_y.size() < n) && (waited < budget)) begin
            @(negedge clock);
            waited++;
        end
        repeat (5) @(negedge clock);
        check({tag, " count"}, out_y.size(), n);
        for (int i = 0; (i < n) && (i < out_y.size()); i++) begin
            check($sformatf("%s y[%0d]", tag, i), out_y[i], exp_y[i]);
            check($sformatf("%s chan[%0d]", tag, i), out_c[i], exp_c[i]);
        end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        rd_viol    = 0;
        wr_viol    = 0;
        pop_cnt    = 0;
        starve     = 1'b0;
        reset      = 1'b1;
        y_out_full = 1'b0;
        x_empty    = 1'b1;
        x_in       = 32'sd0;

        // Reset state with data waiting upstream.
        push_frame(32'sd5, 32'sd7);
        repeat (3) @(negedge clock);
        check("reset x_rd_en", x_rd_en, 0);
        check("reset y_wr_en", y_wr_en, 0);
        check("reset y_out", y_out, 0);
        check("reset y_chan", y_chan, 0);
        do_reset();

        // Impulse response.
        feed_impulse();
        compare_outs("impulse", 3000);

        // DC step on ch1.
        do_reset();
        feed_dc();
        compare_outs("dc_step", 3000);

        // Negative DC on ch0.
        do_reset();
        for (int f = 0; f < 8; f++) push_frame(-32'sd1024, 32'sd0);
        expect_pair(-36, 0);
        compare_outs("neg_dc", 1000);

        // Single -1 sample against coeff[0]: floor of -1/1024 is -1.
        do_reset();
        for (int f = 0; f < 7; f++) push_frame(32'sd0, 32'sd0);
        push_frame(-32'sd1, 32'sd0);
        expect_pair(-1, 0);
        compare_outs("neg_floor", 1000);

        // Back-pressure held in WRITE.
        do_reset();
        y_out_full = 1'b1;
        feed_impulse();
        wait_pops("bp", 16, 500);
        repeat (40) @(negedge clock);
        snap = y_out;
        check("bp stall y_out", y_out, 8);
        check("bp stall y_chan", y_chan, 0);
        check("bp stall y_wr_en", y_wr_en, 0);
        stall_bad = 0;
        repeat (50) begin
            @(negedge clock);
            if ((y_wr_en !== 1'b0) || (x_rd_en !== 1'b0) || (y_out !== snap) || (y_chan !== 1'b0)) stall_bad++;
        end
        check("bp stall hold", stall_bad, 0);
        check("bp stall writes", out_y.size(), 0);
        check("bp stall pops", pop_cnt, 16);
        y_out_full = 1'b0;
        #1;
        check("bp release y_wr_en", y_wr_en, 1);
        compare_outs("backpressure", 3000);

        // Input starvation at 50% duty.
        do_reset();
        starve = 1'b1;
        feed_dc();
        compare_outs("starvation", 6000);
        starve = 1'b0;
        check("starvation rd while empty", rd_viol, 0);

        // Reset in MAC cycle 10, then rerun the impulse.
        do_reset();
        feed_impulse();
        wait_pops("rst", 16, 500);
        repeat (9) @(negedge clock);
        check("rst pre y_out", y_out, 8);
        reset = 1'b1;
        #1;
        check("rst y_wr_en", y_wr_en, 0);
        check("rst y_out", y_out, 0);
        check("rst x_rd_en", x_rd_en, 0);
        do_reset();
        feed_impulse();
        compare_outs("rst_rerun", 3000);

        check("protocol rd while empty", rd_viol, 0);
        check("protocol wr while full", wr_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
